// File: rtl/inst_mem_fetch.sv
// Loadable instruction memory for the CPU fetch stage.
// The program is written through a load port. Fetches are registered, with a
// one-cycle latency and a stall/flush handshake. Fetching the halt opcode
// stops further issue until resume is asserted.
module inst_mem_fetch #(
    parameter int                INST_W   = 9,
    parameter int                OPC_W    = 5,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 256,
    parameter logic [INST_W-1:0] NOP_WORD = 9'h000,
    parameter logic [OPC_W-1:0]  HALT_OPC = 5'b11010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [INST_W-1:0] load_data_i,
    input  logic              resume_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              oob_o,
    output logic              halted_o,
    output logic              load_err_o,
    output logic [ADDR_W-1:0] load_cnt_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              oob_q, oob_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;

    logic [INST_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic              fetch_in_range;
    logic              load_in_range;
    logic [INST_W-1:0] fetch_word;
    logic              err_base;
    logic [ADDR_W-1:0] cnt_base;

    assign fetch_in_range = ({1'b0, pc_i} < DEPTH_L);
    assign load_in_range  = ({1'b0, load_addr_i} < DEPTH_L);
    // The halt opcode must be seen at the same edge the word is captured,
    // so the array is read combinationally and the result is registered below.
    assign fetch_word = fetch_in_range ? mem_q[pc_i[IDX_W-1:0]] : NOP_WORD;

    // Program storage: written only in LOAD and never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[load_addr_i[IDX_W-1:0]] <= load_data_i;
        end
    end

    // Per-cycle priority: load_en > flush > stall > fetch.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;
        oob_d      = oob_q;
        load_err_d = load_err_q;
        load_cnt_d = load_cnt_q;
        mem_we     = 1'b0;
        err_base   = load_err_q;
        cnt_base   = load_cnt_q;

        if (load_en_i) begin
            state_d = ST_LOAD;
            valid_d = 1'b0;
            // Entering LOAD restarts both the error flag and the word count.
            if (state_q != ST_LOAD) begin
                err_base = 1'b0;
                cnt_base = '0;
            end
            if (load_in_range) begin
                mem_we     = 1'b1;
                load_err_d = err_base;
                load_cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
            end else begin
                load_err_d = 1'b1;
                load_cnt_d = cnt_base;
            end
        end else begin
            // Leaving LOAD and resuming are mode changes. They do not depend
            // on the pipeline handshake.
            if (state_q == ST_LOAD) begin
                state_d = ST_RUN;
            end else if (state_q == ST_HALTED && resume_i) begin
                state_d = ST_RUN;
            end

            if (flush_i) begin
                inst_d  = NOP_WORD;
                valid_d = 1'b0;
                oob_d   = 1'b0;
            end else if (!stall_i) begin
                if (state_q == ST_RUN && fetch_req_i) begin
                    inst_d    = fetch_word;
                    inst_pc_d = pc_i;
                    valid_d   = 1'b1;
                    oob_d     = !fetch_in_range;
                    if (fetch_word[INST_W-1 -: OPC_W] == HALT_OPC) begin
                        state_d = ST_HALTED;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    // State and output registers, with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            inst_q     <= NOP_WORD;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
            oob_q      <= 1'b0;
            load_err_q <= 1'b0;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            oob_q      <= oob_d;
            load_err_q <= load_err_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign oob_o        = oob_q;
    assign halted_o     = (state_q == ST_HALTED);
    assign load_err_o   = load_err_q;
    assign load_cnt_o   = load_cnt_q;

endmodule
